// File: rtl/tour_cmd_seq_pkg.sv
// rtl/tour_cmd_seq_pkg.sv - shared types and constants for the tour command sequencer
package tour_cmd_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VERT,
        WAIT_V,
        HORZ,
        WAIT_H
    } state_t;

    localparam logic [3:0] OP_MOVE     = 4'h4;
    localparam logic [3:0] OP_MOVE_FAN = 4'h5;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] DEF_POS_ACK = 8'hA5;
    localparam logic [7:0] DEF_MID_ACK = 8'h5A;

    // Pack opcode, heading and square count into a command word
    function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_cmd_seq_move_decode.sv
// rtl/tour_cmd_seq_move_decode.sv - one-hot knight move to vertical/horizontal command pair
module move_decode
    import tour_cmd_seq_pkg::*;
(
    input  logic [7:0]  mv_reg,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);

    logic [2:0] sel;
    logic       hit;

    // Pick the lowest set bit, then map it to its two legs
    always_comb begin
        sel      = 3'd0;
        hit      = 1'b0;
        vert_cmd = 16'h0000;
        horz_cmd = 16'h0000;
        // Scanning downwards lets the lowest set bit overwrite any higher one
        for (int i = 7; i >= 0; i--) begin
            if (mv_reg[i]) begin
                sel = 3'(i);
                hit = 1'b1;
            end
        end
        if (hit) begin
            case (sel)
                3'd0: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd1); end
                3'd1: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd1); end
                3'd2: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd2); end
                3'd3: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd2); end
                3'd4: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_W, 4'd1); end
                3'd5: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd2); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd1); end
                3'd6: begin vert_cmd = mk_cmd(OP_MOVE, HDG_S, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd2); end
                default: begin vert_cmd = mk_cmd(OP_MOVE, HDG_N, 4'd1); horz_cmd = mk_cmd(OP_MOVE_FAN, HDG_E, 4'd2); end
            endcase
        end
    end

endmodule

// File: rtl/tour_cmd_seq.sv
// rtl/tour_cmd_seq.sv - replays a solved knight tour as movement commands, UART passthrough when idle
module tour_cmd_seq
    import tour_cmd_seq_pkg::*;
#(
    parameter int         NUM_MOVES = 24,
    parameter logic [7:0] POS_ACK   = DEF_POS_ACK,
    parameter logic [7:0] MID_ACK   = DEF_MID_ACK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    output logic        clr_cmd_rdy_UART,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t      state;
    logic [7:0]  mv_reg;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;

    move_decode u_move_decode (
        .mv_reg   (mv_reg),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );

    // Tour sequencing: one handshake per leg, index advances after the horizontal leg completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
            mv_reg  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        mv_indx <= 5'd0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    mv_reg <= move;
                    // An empty move slot marks the end of the stored tour
                    state  <= (move == 8'h00) ? IDLE : VERT;
                end
                VERT: begin
                    if (clr_cmd_rdy) state <= WAIT_V;
                end
                WAIT_V: begin
                    if (send_resp) state <= HORZ;
                end
                HORZ: begin
                    if (clr_cmd_rdy) state <= WAIT_H;
                end
                WAIT_H: begin
                    if (send_resp) begin
                        if (mv_indx == LAST_IDX) begin
                            state <= IDLE;
                        end else begin
                            mv_indx <= mv_indx + 5'd1;
                            state   <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output steering: UART passthrough in idle, decoded legs while touring
    always_comb begin
        cmd              = 16'h0000;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_V: cmd = vert_cmd;
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            WAIT_H: cmd = horz_cmd;
            default: cmd = 16'h0000;
        endcase
    end

    // Acknowledge byte: intermediate moves get the mid ack, idle and final move get the positive ack
    always_comb begin
        resp = ((state != IDLE) && (mv_indx < LAST_IDX)) ? MID_ACK : POS_ACK;
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb/tb_tour_cmd_seq.sv - self-checking bench for tour_cmd_seq
module tb_tour_cmd_seq;
    import tour_cmd_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        clr_cmd_rdy_UART;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    logic [7:0]  tour_mem [0:23];
    int          total  = 0;
    int          passed = 0;
    int          failed = 0;

    assign move = tour_mem[mv_indx];

    always #5 clk = ~clk;

    tour_cmd_seq dut (
        .clk              (clk),
        .rst              (rst),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .send_resp        (send_resp),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .resp             (resp)
    );

    // Reference: lowest set bit selects the knight move; legs from direction/distance masks
    function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
        logic [7:0] south_m = 8'b0111_1000;
        logic [7:0] vtwo_m  = 8'b0011_0011;
        logic [7:0] east_m  = 8'b1110_0001;
        logic [7:0] htwo_m  = 8'b1100_1100;
        int k = 0;
        for (int i = 7; i >= 0; i--) if (mv[i]) k = i;
        if (!horiz) return {4'h4, south_m[k] ? 8'h7F : 8'h00, vtwo_m[k] ? 4'd2 : 4'd1};
        return {4'h5, east_m[k] ? 8'hBF : 8'h3F, htwo_m[k] ? 4'd2 : 4'd1};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (cmd_rdy !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_rdy_timeout"}, 16'(cmd_rdy), 16'h1);
    endtask

    // Service one tour command: check it, take it, then signal move-complete
    task automatic serve_cmd(input string tag, input logic [15:0] exp_cmd,
                             input logic [4:0] exp_idx, input logic [7:0] exp_resp);
        wait_rdy(tag);
        chk({tag, "_cmd"}, cmd, exp_cmd);
        chk({tag, "_idx"}, 16'(mv_indx), 16'(exp_idx));
        chk({tag, "_resp"}, 16'(resp), 16'(exp_resp));
        clr_cmd_rdy = 1'b1;
        #1;
        chk({tag, "_uart_clr_blocked"}, 16'(clr_cmd_rdy_UART), 16'h0);
        tick;
        clr_cmd_rdy = 1'b0;
        chk({tag, "_rdy_drop"}, 16'(cmd_rdy), 16'h0);
        tick;
        chk({tag, "_rdy_wait"}, 16'(cmd_rdy), 16'h0);
        send_resp = 1'b1;
        tick;
        send_resp = 1'b0;
    endtask

    initial begin
        logic [15:0] pend;
        rst          = 1'b1;
        start_tour   = 1'b0;
        cmd_UART     = 16'h4004;
        cmd_rdy_UART = 1'b1;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        for (int i = 0; i < 24; i++) tour_mem[i] = 8'h01;
        tick;
        tick;
        rst = 1'b0;

        // Reset state and idle passthrough
        chk("rst_idx", 16'(mv_indx), 16'h0);
        chk("idle_cmd", cmd, 16'h4004);
        chk("idle_rdy", 16'(cmd_rdy), 16'h1);
        chk("idle_resp", 16'(resp), 16'hA5);
        clr_cmd_rdy = 1'b1;
        #1;
        chk("idle_clr_echo", 16'(clr_cmd_rdy_UART), 16'h1);
        clr_cmd_rdy = 1'b0;
        #1;
        chk("idle_clr_echo0", 16'(clr_cmd_rdy_UART), 16'h0);
        tick;

        // Single decode with directed timing; pending UART command held off
        for (int i = 0; i < 24; i++) tour_mem[i] = 8'h01 << $urandom_range(7, 0);
        tour_mem[0]  = 8'h01;
        cmd_UART     = 16'h4123;
        cmd_rdy_UART = 1'b1;
        start_tour   = 1'b1;
        tick;
        start_tour = 1'b0;
        chk("load_no_rdy", 16'(cmd_rdy), 16'h0);
        tick;
        chk("vert_rdy", 16'(cmd_rdy), 16'h1);
        chk("vert_cmd", cmd, 16'h4002);
        chk("vert_resp", 16'(resp), 16'h5A);
        tick;
        chk("vert_hold", cmd, 16'h4002);
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        #1;
        chk("tour_uart_clr", 16'(clr_cmd_rdy_UART), 16'h0);
        tick;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        chk("waitv_rdy", 16'(cmd_rdy), 16'h0);
        tick;
        tick;
        chk("no_horz_early", 16'(cmd_rdy), 16'h0);
        start_tour = 1'b1;
        tick;
        start_tour = 1'b0;
        chk("restart_ignored_idx", 16'(mv_indx), 16'h0);
        chk("restart_ignored_rdy", 16'(cmd_rdy), 16'h0);
        send_resp = 1'b1;
        tick;
        send_resp = 1'b0;
        chk("horz_rdy", 16'(cmd_rdy), 16'h1);
        chk("horz_cmd", cmd, 16'h5BF1);
        clr_cmd_rdy = 1'b1;
        tick;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b1;
        tick;
        send_resp = 1'b0;

        // Second move, then reset while its horizontal leg is offered
        serve_cmd("m1v", leg_cmd(tour_mem[1], 1'b0), 5'd1, 8'h5A);
        wait_rdy("m1h");
        chk("m1h_cmd", cmd, leg_cmd(tour_mem[1], 1'b1));
        cmd_UART = 16'(($urandom));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_mid_idx", 16'(mv_indx), 16'h0);
        chk("rst_mid_rdy", 16'(cmd_rdy), 16'(cmd_rdy_UART));
        chk("rst_mid_cmd", cmd, cmd_UART);
        chk("rst_mid_resp", 16'(resp), 16'hA5);
        tick;
        tick;
        chk("rst_no_reissue", cmd, cmd_UART);

        // Full randomized tour with a pending UART command
        for (int i = 0; i < 24; i++) begin
            tour_mem[i] = 8'h01 << $urandom_range(7, 0);
            if ($urandom_range(3, 0) == 0) tour_mem[i] = tour_mem[i] | (8'h01 << $urandom_range(7, 0));
        end
        pend         = 16'(($urandom));
        cmd_UART     = pend;
        cmd_rdy_UART = 1'b1;
        start_tour   = 1'b1;
        tick;
        start_tour = 1'b0;
        for (int i = 0; i < 24; i++) begin
            serve_cmd($sformatf("t%0dv", i), leg_cmd(tour_mem[i], 1'b0), 5'(i), (i < 23) ? 8'h5A : 8'hA5);
            serve_cmd($sformatf("t%0dh", i), leg_cmd(tour_mem[i], 1'b1), 5'(i), (i < 23) ? 8'h5A : 8'hA5);
        end
        chk("end_idx", 16'(mv_indx), 16'd23);
        chk("end_resp", 16'(resp), 16'hA5);
        chk("end_pending_cmd", cmd, pend);
        chk("end_pending_rdy", 16'(cmd_rdy), 16'h1);
        clr_cmd_rdy = 1'b1;
        #1;
        chk("end_pending_clr", 16'(clr_cmd_rdy_UART), 16'h1);
        clr_cmd_rdy  = 1'b0;
        cmd_rdy_UART = 1'b0;
        tick;

        // Multi-hot move then an empty slot ending the tour
        tour_mem[0] = 8'h30;
        tour_mem[1] = 8'h00;
        start_tour  = 1'b1;
        tick;
        start_tour = 1'b0;
        serve_cmd("mh_v", 16'h47F2, 5'd0, 8'h5A);
        serve_cmd("mh_h", 16'h53F1, 5'd0, 8'h5A);
        tick;
        chk("zero_move_rdy", 16'(cmd_rdy), 16'h0);
        chk("zero_move_resp", 16'(resp), 16'hA5);
        tick;
        tick;
        chk("zero_move_rdy_late", 16'(cmd_rdy), 16'h0);
        cmd_rdy_UART = 1'b1;
        #1;
        chk("zero_move_idle", 16'(cmd_rdy), 16'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
